// File: rtl/riscv_wb_pkg.sv
// Shared writeback types and widths for the integer pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_wb_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One queued register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_sequencer_fifo.sv
// Circular writeback queue: rd/data storage, pointers, occupancy, per-entry valid.
// Latency: push visible at head one edge later; pop advances head on the edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module wb_fifo #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [4:0]           push_rd,
  input  logic [XLEN-1:0]      push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count,
  output logic [4:0]           head_rd,
  output logic [XLEN-1:0]      head_data,
  output logic [DEPTH-1:0]     ent_vld,
  output logic [DEPTH*5-1:0]   ent_rd
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [4:0]       rd_mem_d   [DEPTH];
  logic [XLEN-1:0]  data_mem_q [DEPTH];
  logic [XLEN-1:0]  data_mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap for free since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write at the tail slot; storage itself is never cleared.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (do_push) begin
      rd_mem_d[wr_ptr_q]   = push_rd;
      data_mem_d[wr_ptr_q] = push_data;
    end
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    ent_vld = '0;
    ent_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] off;
      off          = PTR_W'(i) - rd_ptr_q;
      ent_vld[i]   = ({1'b0, off} < count_q);
      ent_rd[i*5 +: 5] = rd_mem_q[i];
    end
  end

  // Pointer and occupancy state; only the valid state is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage registers.
  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Merges ALU and load results into one in-order register-file write port.
// Latency: transfer at edge N -> reg_write in the cycle after edge N+1; one write/cycle.
// Backpressure: ready drops when the queue is full or in reset; alu also yields to mem.
module writeback_sequencer #(
  parameter int XLEN  = riscv_wb_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     mem_ready,
  input  logic                     wb_stall,
  output logic                     reg_write,
  output logic [4:0]               wb_rd,
  output logic [XLEN-1:0]          wb_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  import riscv_wb_pkg::*;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [4:0]              head_rd;
  logic [XLEN-1:0]         head_data;
  logic [DEPTH-1:0]        ent_vld;
  logic [DEPTH*5-1:0]      ent_rd;

  logic                    mem_xfer;
  logic                    alu_xfer;
  logic [4:0]              sel_rd;
  logic [XLEN-1:0]         sel_data;
  logic                    push;
  logic                    pop;

  logic                    reg_write_q, reg_write_d;
  logic [4:0]              wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;

  // Source arbitration: load results win; no bypass when full.
  always_comb begin
    mem_ready = !reset && !fifo_full;
    alu_ready = !reset && !fifo_full && !mem_valid;
    mem_xfer  = mem_valid && mem_ready;
    alu_xfer  = alu_valid && alu_ready;
    sel_rd    = mem_xfer ? mem_rd   : alu_rd;
    sel_data  = mem_xfer ? mem_data : alu_data;
    // Writes to x0 complete the handshake but are dropped here.
    push      = (mem_xfer || alu_xfer) && (sel_rd != '0);
    pop       = !reset && !wb_stall;
  end

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (sel_rd),
    .push_data (sel_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .head_rd   (head_rd),
    .head_data (head_data),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
  );

  // Present the head for one cycle per pop; otherwise hold address/data.
  always_comb begin
    reg_write_d = pop && !fifo_empty;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    if (reg_write_d) begin
      wb_rd_d   = head_rd;
      wb_data_d = head_data;
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign reg_write = reg_write_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

  // Scoreboard view: every live queue entry plus the write being presented.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending[ent_rd[i*5 +: 5]] = 1'b1;
    end
    if (reg_write_q) pending[wb_rd_q] = 1'b1;
    pending[0] = 1'b0;
    if (reset) pending = '0;
  end

endmodule

// File: doc/writeback_sequencer.md
WRITEBACK_SEQUENCER -- requirements
Module: writeback_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data width of writeback values.
REQ-002 SHALL have parameter DEPTH, default 4, meaning writeback queue entries (power of two).
REQ-003 SHALL have ports: clk  in  1  clock; reset  in  1  reset (synchronous, active-high).
REQ-004 SHALL have ports: alu_valid  in  1  ALU result offered; alu_rd  in  5  ALU destination; alu_data  in  XLEN  ALU result; alu_ready  out  1  ALU result accepted.
REQ-005 SHALL have ports: mem_valid  in  1  load result offered; mem_rd  in  5  load destination; mem_data  in  XLEN  load data; mem_ready  out  1  load result accepted.
REQ-006 SHALL have ports: wb_stall  in  1  hold register-file writes; reg_write  out  1  register-file write enable; wb_rd  out  5  write address; wb_data  out  XLEN  write data.
REQ-007 SHALL have ports: pending  out  32  bit i set while a write to x[i] is queued or being presented; count  out  $clog2(DEPTH)+1  queue occupancy.
REQ-008 Reset is reset, synchronous, active-high; clock is clk; all state changes on rising clk only.

Function
REQ-009 A source transfer SHALL occur on a rising edge where valid and ready are both high.
REQ-010 At most one source transfer SHALL occur per cycle; mem has fixed priority over alu.
REQ-011 mem_ready SHALL be high iff not reset and count < DEPTH.
REQ-012 alu_ready SHALL be high iff not reset, count < DEPTH, and mem_valid is low.
REQ-013 A transfer with rd = 0 SHALL be accepted (handshake completes) but not enqueued and SHALL not change pending.
REQ-014 A transfer with rd != 0 SHALL append {rd, data} to the queue tail in FIFO order.
REQ-015 On each edge with count > 0 and wb_stall low, the head SHALL be popped into wb_rd/wb_data with reg_write = 1 for the following cycle.
REQ-016 On each edge with count = 0 or wb_stall high, reg_write SHALL go to 0; wb_rd/wb_data SHALL hold their values.
REQ-017 Minimum latency: transfer at edge N -> reg_write high in the cycle after edge N+1; one write per cycle sustained.
REQ-018 Simultaneous enqueue and pop SHALL leave count unchanged; with count = DEPTH, ready stays low even if a pop occurs that edge (no full-bypass).
REQ-019 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-020 pending SHALL be combinational: OR of decoded rd over valid queue entries, plus wb_rd when reg_write is high; bit 0 always 0.
REQ-021 Duplicate rd in the queue SHALL be written in order; pending[rd] stays set until the last such entry's write cycle ends.

Reset
REQ-022 While reset is high at an edge: count = 0, pointers = 0, reg_write = 0, wb_rd = 0, wb_data = 0; queued entries discarded.
REQ-023 While reset is high, alu_ready = mem_ready = 0 and pending = 0; a reset mid-operation drops in-flight entries with no write issued.
REQ-024 Queue storage contents need not be reset; only the valid state is.

Structure
REQ-025 Package riscv_wb_pkg SHALL hold XLEN, REG_ADDR_W = 5, NUM_REGS = 32 and the wb_entry_t struct {rd, data}.
REQ-026 Queue storage and pointer/count logic SHALL be a sub-module wb_fifo (push, pop, full, empty, count, head entry, entry-valid vector).
REQ-027 Arbitration, rd = 0 filtering, output registers and pending decode SHALL be in writeback_sequencer.

Verification
REQ-028 Reset then single ALU transfer rd=5, data=0x1234 at edge 1 -> reg_write=1, wb_rd=5, wb_data=0x1234 in cycle after edge 2; pending[5]=1 from edge 1 until that write cycle ends.
REQ-029 alu_valid and mem_valid same cycle (alu rd=3/0xA, mem rd=4/0xB) -> mem accepted first, alu_ready=0 that cycle; writes appear x4=0xB then x3=0xA.
REQ-030 wb_stall=1 with 5 ALU offers (rd 1..5) -> 4 accepted, count=4, alu_ready=0, no reg_write; release stall -> writes x1..x4 on consecutive cycles, then 5th accepted and written.
REQ-031 Transfer rd=0, data=0xFFFF -> handshake completes, count stays 0, reg_write never asserts, pending=0.
REQ-032 Two queued writes to rd=7 (0x1, 0x2) -> written in order, pending[7] clears only after the 0x2 write cycle.
REQ-033 Reset asserted with count=3 -> next cycle count=0, reg_write=0, pending=0; none of the three entries written.
